// File: rtl/bundle_pkg.sv
// Shared bus types for the word-granular burst bus, plus responder FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bundle;

  // Longest burst a single request may ask for; length fields are sized to fit it.
  localparam int BUS_MAX_BURST = 15;
  localparam int BUS_LEN_W     = $clog2(BUS_MAX_BURST + 1);

  typedef logic [31:0] paddr_t;

  // Initiator -> responder.
  typedef struct packed {
    logic                 awvalid;
    paddr_t               awaddr;
    logic [BUS_LEN_W-1:0] wlen;
    logic                 wvalid;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic                 wlast;
    logic                 bready;
    logic                 arvalid;
    paddr_t               araddr;
    logic [BUS_LEN_W-1:0] rlen;
    logic                 rready;   // read data ready
  } bus_query_req_t;

  // Responder -> initiator.
  typedef struct packed {
    logic        awready;
    logic        wready;
    logic        bvalid;
    logic        rready;            // read address ready
    logic        rvalid;
    logic [31:0] rdata;
    logic        rlast;
  } bus_query_resp_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ACCESS = 3'd1,
    RD_HOLD   = 3'd2,
    WR_DATA   = 3'd3,
    WR_PULSE  = 3'd4,
    WR_RESP   = 3'd5
  } sram_resp_state_t;

endpackage

// File: rtl/bus_sram_responder.sv
// Burst-bus responder driving one 32-bit async SRAM; one transaction at a time.
// Latency: read accept at T -> first rvalid at T+1+READ_CYCLES; READ_CYCLES+1 per further beat;
// write beats take WRITE_CYCLES after wvalid. Backpressure: rdata held until rready, bvalid until bready.
// Optional BUS_WLAST_CHECK_EN: sticky protocol_err when wlast disagrees with the wlen beat count.
module bus_sram_responder
  import bundle::*;
#(
  parameter int ADDR_W       = 20,
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  bus_query_req_t       req,
  output bus_query_resp_t      resp,
  output logic [ADDR_W-1:0]    sram_addr,
  input  logic [31:0]          sram_dq_i,
  output logic [31:0]          sram_dq_o,
  output logic                 sram_dq_oe,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic [3:0]           sram_be_n,
  output logic                 protocol_err
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]     RD_LAST  = CNT_W'(READ_CYCLES);
  localparam logic [CNT_W-1:0]     WR_LAST  = CNT_W'(WRITE_CYCLES);
  localparam logic [BUS_LEN_W-1:0] LEN_ONE  = BUS_LEN_W'(1);
  localparam logic [ADDR_W-1:0]    ADDR_ONE = ADDR_W'(1);

  sram_resp_state_t     state;
  logic [ADDR_W-1:0]    addr;        // word address of the current beat
  logic [BUS_LEN_W-1:0] remaining;   // beats left including the current one
  logic [CNT_W-1:0]     cnt;         // cycle counter within a read access or write beat
  logic                 last_beat;

  assign last_beat = (remaining == LEN_ONE);

  // Byte-offset and upper address bits are outside the SRAM word space; wlast only matters
  // when the length check is compiled in.
  logic unused_req_bits;
  assign unused_req_bits = ^{req.awaddr[1:0], req.awaddr[31:ADDR_W+2],
                             req.araddr[1:0], req.araddr[31:ADDR_W+2], req.wlast};

  // Main FSM: request acceptance, SRAM pin timing and bus response, all registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      resp       <= '0;
      addr       <= '0;
      remaining  <= '0;
      cnt        <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 4'hF;
`ifdef BUS_WLAST_CHECK_EN
      protocol_err <= 1'b0;
`endif
    end else begin
      // Address/data acceptance strobes are single-cycle pulses.
      resp.awready <= 1'b0;
      resp.rready  <= 1'b0;
      resp.wready  <= 1'b0;

      case (state)
        IDLE: begin
          if (req.awvalid && (req.wlen != '0)) begin
            // Writes win a tie so a pending read never starves a write-back.
            resp.awready <= 1'b1;
            addr         <= req.awaddr[ADDR_W+1:2];
            remaining    <= req.wlen;
            state        <= WR_DATA;
          end else if (req.arvalid && (req.rlen != '0)) begin
            resp.rready <= 1'b1;
            addr        <= req.araddr[ADDR_W+1:2];
            remaining   <= req.rlen;
            cnt         <= '0;
            state       <= RD_ACCESS;
          end
        end

        RD_ACCESS: begin
          if (cnt == RD_LAST) begin
            // Pins have been stable for READ_CYCLES cycles: capture and release.
            resp.rdata  <= sram_dq_i;
            resp.rvalid <= 1'b1;
            resp.rlast  <= last_beat;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_be_n   <= 4'hF;
            state       <= RD_HOLD;
          end else begin
            // cnt==0 only on the first beat, where this edge first drives the pins.
            sram_addr <= addr;
            sram_ce_n <= 1'b0;
            sram_oe_n <= 1'b0;
            sram_be_n <= 4'h0;
            cnt       <= cnt + CNT_ONE;
          end
        end

        RD_HOLD: begin
          if (req.rready) begin
            resp.rvalid <= 1'b0;
            resp.rlast  <= 1'b0;
            addr        <= addr + ADDR_ONE;
            remaining   <= remaining - LEN_ONE;
            if (last_beat) begin
              state <= IDLE;
            end else begin
              // Start the next access on the handshake edge so a beat costs READ_CYCLES+1.
              sram_addr <= addr + ADDR_ONE;
              sram_ce_n <= 1'b0;
              sram_oe_n <= 1'b0;
              sram_be_n <= 4'h0;
              cnt       <= CNT_ONE;
              state     <= RD_ACCESS;
            end
          end
        end

        WR_DATA: begin
          if (req.wvalid) begin
            resp.wready <= 1'b1;
            sram_addr   <= addr;
            sram_dq_o   <= req.wdata;
            sram_be_n   <= ~req.wstrb;
            sram_ce_n   <= 1'b0;
            sram_dq_oe  <= 1'b1;
            sram_we_n   <= 1'b1;       // setup cycle
            cnt         <= CNT_ONE;
            state       <= WR_PULSE;
`ifdef BUS_WLAST_CHECK_EN
            if (req.wlast != last_beat) begin
              protocol_err <= 1'b1;
            end
`endif
          end
        end

        WR_PULSE: begin
          if (cnt == WR_LAST) begin
            // Hold cycle done: release the bus and advance.
            sram_ce_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_be_n  <= 4'hF;
            addr       <= addr + ADDR_ONE;
            remaining  <= remaining - LEN_ONE;
            if (last_beat) begin
              resp.bvalid <= 1'b1;
              state       <= WR_RESP;
            end else begin
              state <= WR_DATA;
            end
          end else begin
            // WE low on all middle cycles, high again on the final hold cycle.
            cnt       <= cnt + CNT_ONE;
            sram_we_n <= ((cnt + CNT_ONE) == WR_LAST);
          end
        end

        WR_RESP: begin
          if (req.bready) begin
            resp.bvalid <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifndef BUS_WLAST_CHECK_EN
  assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_sram_responder.sv
// Directed bench for bus_sram_responder with an SRAM model and read/write scoreboards.
// Latency: n/a. Backpressure: exercises rready stalls and bready hold.
// Expectations for BUS_WLAST_CHECK_EN follow the same macro.
module tb_bus_sram_responder;
  import bundle::*;

  logic            clk = 1'b0;
  logic            rst;
  bus_query_req_t  req;
  bus_query_resp_t resp;
  logic [19:0]     sram_addr;
  logic [31:0]     sram_dq_i;
  logic [31:0]     sram_dq_o;
  logic            sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]      sram_be_n;
  logic            protocol_err;

  bus_sram_responder #(.ADDR_W(20), .READ_CYCLES(2), .WRITE_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .req(req), .resp(resp),
    .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int arready_cnt = 0;

  typedef struct { logic [19:0] a; logic [31:0] d; logic l; } rd_exp_t;
  typedef struct { logic [19:0] a; logic [31:0] d; logic [3:0] be_n; } wr_exp_t;
  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  rd_exp_t re;
  wr_exp_t we;

  // SRAM model: 1K words indexed by the low address bits (test addresses do not alias).
  logic [31:0] mem [0:1023];
  logic [9:0]  pre_a = '0;
  logic [31:0] pre_d = '0;
  logic        pre_en = 1'b0;
  logic        we_prev = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be_n);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (!be_n[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Monitor + SRAM model, all on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (!rst) begin
      if (resp.rvalid && req.rready) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
        else begin
          re = rd_q.pop_front();
          chk("rd_data", resp.rdata, re.d);
          chk("rd_last", resp.rlast, re.l);
          chk("rd_addr", sram_addr, re.a);
        end
      end
      if (!sram_we_n && we_prev) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
        else begin
          we = wr_q.pop_front();
          chk("wr_addr", sram_addr, we.a);
          chk("wr_data", sram_dq_o, we.d);
          chk("wr_be_n", sram_be_n, we.be_n);
          chk("wr_dq_oe", sram_dq_oe, 1);
          chk("wr_ce_n", sram_ce_n, 0);
        end
      end
      if (resp.rready) arready_cnt <= arready_cnt + 1;
    end
    we_prev <= sram_we_n;
    if (pre_en) mem[pre_a] <= pre_d;
    else if (!sram_we_n && !sram_ce_n)
      mem[sram_addr[9:0]] <= merge(mem[sram_addr[9:0]], sram_dq_o, sram_be_n);
    sram_dq_i <= (!sram_oe_n && !sram_ce_n) ? mem[sram_addr[9:0]] : 32'h0;
  end

  function automatic logic sig(input int w);
    case (w)
      0: return resp.awready;
      1: return resp.rready;
      2: return resp.wready;
      3: return resp.rvalid;
      4: return resp.bvalid;
      5: return !sram_we_n;
      default: return (rd_q.size() == 0);
    endcase
  endfunction

  // Returns at the falling edge where the selected condition holds, or flags a timeout.
  task automatic wait_for(input int w, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!sig(w) && n < 200);
    if (!sig(w)) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pre_a = a; pre_d = d; pre_en = 1'b1;
    @(negedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic push_rd(input logic [19:0] a, input logic [31:0] d, input logic l);
    rd_exp_t e;
    e.a = a; e.d = d; e.l = l;
    rd_q.push_back(e);
  endtask

  task automatic push_wr(input logic [19:0] a, input logic [31:0] d, input logic [3:0] be_n);
    wr_exp_t e;
    e.a = a; e.d = d; e.be_n = be_n;
    wr_q.push_back(e);
  endtask

  task automatic do_read(input logic [31:0] a, input int len, input string tag);
    @(posedge clk); #1;
    req.araddr = a; req.rlen = 4'(len); req.arvalid = 1'b1; req.rready = 1'b1;
    wait_for(1, {tag, "_ar"});
    @(posedge clk); #1;
    req.arvalid = 1'b0;
    wait_for(6, {tag, "_drain"});
  endtask

  task automatic do_write(input logic [31:0] a, input int len, input logic [31:0] d0,
                          input logic [3:0] strb, input int last_beat, input int bstall);
    @(posedge clk); #1;
    req.awaddr = a; req.wlen = 4'(len); req.awvalid = 1'b1;
    wait_for(0, "aw");
    @(posedge clk); #1;
    req.awvalid = 1'b0;
    for (int i = 0; i < len; i++) begin
      req.wdata = d0 + 32'(i) * 32'h44444444;
      req.wstrb = strb; req.wlast = (i == last_beat); req.wvalid = 1'b1;
      wait_for(2, "w");
      @(posedge clk); #1;
      req.wvalid = 1'b0;
    end
    wait_for(4, "b");
    repeat (bstall) begin @(negedge clk); chk("bvalid_hold", resp.bvalid, 1); end
    @(posedge clk); #1; req.bready = 1'b1;
    @(posedge clk); #1; req.bready = 1'b0;
    @(negedge clk); chk("bvalid_clear", resp.bvalid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c0;
    rst = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_resp", {63'd0, resp === '0}, 1);
    chk("rst_ce_n", sram_ce_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_be_n", sram_be_n, 4'hF);
    chk("rst_dq_oe", sram_dq_oe, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dq_o", sram_dq_o, 0);
    chk("rst_perr", protocol_err, 0);
    chk("rst_state", dut.state, IDLE);
    @(posedge clk); #1; rst = 1'b0;

    // Zero-length read is ignored
    @(posedge clk); #1;
    req.araddr = 32'h10; req.rlen = 4'd0; req.arvalid = 1'b1;
    c0 = arready_cnt;
    repeat (5) @(negedge clk);
    chk("len0_ignored", 64'(arready_cnt - c0), 0);
    chk("len0_idle", dut.state, IDLE);
    @(posedge clk); #1; req.arvalid = 1'b0;

    // Single read with latency measurement
    preload(10'h004, 32'hDEADBEEF);
    push_rd(20'h00004, 32'hDEADBEEF, 1'b1);
    @(posedge clk); #1;
    req.araddr = 32'h0000_0010; req.rlen = 4'd1; req.arvalid = 1'b1; req.rready = 1'b1;
    wait_for(1, "single_ar");
    @(posedge clk); #1; req.arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp.rvalid && n < 20);
    chk("single_latency", 64'(n), 3);
    chk("single_rdata", resp.rdata, 32'hDEADBEEF);
    chk("single_rlast", resp.rlast, 1);
    @(negedge clk);
    chk("single_idle", dut.state, IDLE);
    chk("single_rvalid_low", resp.rvalid, 0);

    // Burst read with a two-cycle stall on beat 2
    for (int i = 0; i < 4; i++) begin
      preload(10'(32'h40 + i), 32'hA000_0040 + 32'(i));
      push_rd(20'(32'h40 + i), 32'hA000_0040 + 32'(i), i == 3);
    end
    @(posedge clk); #1;
    req.araddr = 32'h100; req.rlen = 4'd4; req.arvalid = 1'b1; req.rready = 1'b1;
    wait_for(1, "burst_ar");
    @(posedge clk); #1; req.arvalid = 1'b0;
    wait_for(3, "burst_b1");
    @(posedge clk); #1; req.rready = 1'b0;
    wait_for(3, "burst_b2");
    chk("stall1_rdata", resp.rdata, 32'hA000_0041);
    chk("stall1_rlast", resp.rlast, 0);
    @(negedge clk);
    chk("stall2_rvalid", resp.rvalid, 1);
    chk("stall2_rdata", resp.rdata, 32'hA000_0041);
    chk("stall2_rlast", resp.rlast, 0);
    chk("stall2_addr", sram_addr, 20'h00041);
    @(posedge clk); #1; req.rready = 1'b1;
    wait_for(6, "burst_drain");

    // Burst write with partial strobes, then read back the merged words
    preload(10'h080, 32'hAAAAAAAA);
    preload(10'h081, 32'hBBBBBBBB);
    push_wr(20'h00080, 32'h11223344, 4'b1100);
    push_wr(20'h00081, 32'h55667788, 4'b1100);
    do_write(32'h200, 2, 32'h11223344, 4'b0011, 1, 3);
    chk("wr_all_pulses", 64'(wr_q.size()), 0);
    chk("wr_dq_oe_idle", sram_dq_oe, 0);
    push_rd(20'h00080, 32'hAAAA3344, 1'b0);
    push_rd(20'h00081, 32'hBBBB7788, 1'b1);
    do_read(32'h200, 2, "wr_readback");

    // Simultaneous write and read requests: write first
    preload(10'h100, 32'h0BADCAFE);
    push_wr(20'h000C0, 32'hCAFEF00D, 4'b0000);
    push_rd(20'h00100, 32'h0BADCAFE, 1'b1);
    @(posedge clk); #1;
    req.awaddr = 32'h300; req.wlen = 4'd1; req.awvalid = 1'b1;
    req.araddr = 32'h400; req.rlen = 4'd1; req.arvalid = 1'b1; req.rready = 1'b1;
    c0 = arready_cnt;
    wait_for(0, "simul_aw");
    chk("simul_no_arready", resp.rready, 0);
    @(posedge clk); #1;
    req.awvalid = 1'b0;
    req.wdata = 32'hCAFEF00D; req.wstrb = 4'hF; req.wlast = 1'b1; req.wvalid = 1'b1;
    wait_for(2, "simul_w");
    @(posedge clk); #1; req.wvalid = 1'b0;
    wait_for(4, "simul_b");
    chk("simul_read_deferred", 64'(arready_cnt - c0), 0);
    @(posedge clk); #1; req.bready = 1'b1;
    @(posedge clk); #1; req.bready = 1'b0;
    wait_for(1, "simul_ar");
    @(posedge clk); #1; req.arvalid = 1'b0;
    wait_for(6, "simul_drain");

    // Address wrap at the top of the SRAM
    preload(10'h3FF, 32'h7777_FFFF);
    preload(10'h000, 32'h5555_0000);
    push_rd(20'hFFFFF, 32'h7777_FFFF, 1'b0);
    push_rd(20'h00000, 32'h5555_0000, 1'b1);
    do_read(32'h003F_FFFC, 2, "wrap");

    // Reset in the middle of a write pulse
    push_wr(20'h00150, 32'h12345678, 4'b0000);
    @(posedge clk); #1;
    req.awaddr = 32'h540; req.wlen = 4'd2; req.awvalid = 1'b1;
    wait_for(0, "rstw_aw");
    @(posedge clk); #1;
    req.awvalid = 1'b0;
    req.wdata = 32'h12345678; req.wstrb = 4'hF; req.wlast = 1'b0; req.wvalid = 1'b1;
    wait_for(5, "rstw_we");
    #1; rst = 1'b1; req = '0;
    #1;
    chk("rstw_we_n", sram_we_n, 1);
    chk("rstw_dq_oe", sram_dq_oe, 0);
    chk("rstw_ce_n", sram_ce_n, 1);
    chk("rstw_resp", {63'd0, resp === '0}, 1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1; rst = 1'b0;
    push_rd(20'h000C0, 32'hCAFEF00D, 1'b1);
    do_read(32'h300, 1, "post_rst_read");
    chk("perr_clean", protocol_err, 0);

    // Early wlast on beat 2 of 3; all three beats still written
    push_wr(20'h00180, 32'h01020304, 4'b0000);
    push_wr(20'h00181, 32'h45464748, 4'b0000);
    push_wr(20'h00182, 32'h898A8B8C, 4'b0000);
    do_write(32'h600, 3, 32'h01020304, 4'hF, 1, 0);
    chk("wlast_all_beats", 64'(wr_q.size()), 0);
`ifdef BUS_WLAST_CHECK_EN
    chk("wlast_perr", protocol_err, 1);
`else
    chk("wlast_perr", protocol_err, 0);
`endif
    repeat (3) @(negedge clk);
`ifdef BUS_WLAST_CHECK_EN
    chk("wlast_perr_sticky", protocol_err, 1);
`else
    chk("wlast_perr_sticky", protocol_err, 0);
`endif
    chk("final_rd_q_empty", 64'(rd_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_sram_responder.md
Name: bus_sram_responder

Overview:
Responder (slave) end of the team's word-granular burst bus. It accepts `bus_query_req_t` requests from an initiator (cache or MMU) and answers with `bus_query_resp_t`. Each request is translated into timed accesses on one 32-bit asynchronous SRAM chip. It sits between the bus arbiter and the board SRAM pins, and serves one transaction at a time.

Parameters:
ADDR_W, 20, SRAM word-address width; word address = paddr[ADDR_W+1:2].
READ_CYCLES, 2, cycles the SRAM address and OE are held before read data is sampled (>=1).
WRITE_CYCLES, 3, cycles per write beat: 1 setup, WRITE_CYCLES-2 with WE low, 1 hold (>=3).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req  in  bus_query_req_t  bus request from initiator
resp  out  bus_query_resp_t  bus response to initiator
sram_addr  out  ADDR_W  SRAM word address
sram_dq_i  in  32  SRAM data in
sram_dq_o  out  32  SRAM data out
sram_dq_oe  out  1  tri-state enable for sram_dq_o
sram_ce_n  out  1  chip enable, active low
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low
sram_be_n  out  4  byte enables, active low
protocol_err  out  1  sticky wlast mismatch flag (see Optional Feature)

Behaviour:
- Reset values:
  - FSM goes to IDLE.
  - All resp fields are 0.
  - ce_n = oe_n = we_n = 1, be_n = 4'hF, dq_oe = 0, sram_addr = 0, sram_dq_o = 0, protocol_err = 0.
  - Reset asserted mid-burst aborts the burst immediately; no response is issued for it.
- FSM states: IDLE, RD_ACCESS, RD_HOLD, WR_DATA, WR_PULSE, WR_RESP.
- IDLE, request acceptance:
  - Write has priority when awvalid and arvalid are both high.
  - Write accept: awvalid && wlen!=0.
    - Pulse resp.awready=1 for one cycle.
    - Latch word address and beat count = wlen (1..15 beats), then go to WR_DATA.
  - Read accept: arvalid && rlen!=0 and no write accepted.
    - Pulse resp.rready (the read-address ready) for one cycle.
    - Latch address and beat count = rlen, then go to RD_ACCESS.
  - A valid with len=0 is ignored and never acknowledged.
- RD_ACCESS:
  - Drive sram_addr, ce_n=0, oe_n=0, be_n=0.
  - Run for READ_CYCLES cycles; on the last cycle register sram_dq_i into resp.rdata, then go to RD_HOLD.
- RD_HOLD:
  - resp.rvalid=1; resp.rlast=1 on the final beat.
  - rdata and rlast are held stable until req.rready.
  - On handshake: word address += 1 (wraps modulo 2^ADDR_W), remaining -= 1.
  - Next state is RD_ACCESS, or IDLE after the last beat.
  - Latency: request accepted in cycle T gives first rvalid in cycle T+1+READ_CYCLES.
  - With rready held high, each subsequent beat takes READ_CYCLES+1 cycles.
- WR_DATA:
  - Wait for req.wvalid.
  - On wvalid: latch wdata and wstrb, pulse resp.wready=1 for one cycle, go to WR_PULSE.
- WR_PULSE:
  - Throughout: ce_n=0, dq_oe=1, sram_dq_o = latched data, be_n = ~wstrb.
  - we_n=0 on every cycle except the first and last.
  - Afterwards: address += 1 (wraps) and go to WR_DATA, or to WR_RESP after the last beat.
- WR_RESP: resp.bvalid=1 until req.bready, then go to IDLE.
- Outside active phases: oe_n=1 and we_n=1; dq_oe=0 in every non-write state (no bus contention).
- resp.awready and the read-address rready are only ever asserted in IDLE.

Optional Feature:
BUS_WLAST_CHECK_EN.
- Defined:
  - On each accepted write beat, compare req.wlast with (remaining==1).
  - On a mismatch, set protocol_err; it stays set until reset.
  - Transfer length is still governed by wlen.
- Undefined: wlast is ignored and protocol_err is tied to 0.

Decomposition:
- The `bundle` package already holds `bus_query_req_t`, `bus_query_resp_t` and `paddr_t`; add there:
  - `sram_resp_state_t` enum (the six states);
  - localparam `BUS_MAX_BURST = 15`.
- The cycle counters for READ_CYCLES and WRITE_CYCLES are inline.
- No sub-module; a single FSM module is natural.

Test Plan:
- Single read: araddr=0x0000_0010, rlen=1, SRAM word 4 = 0xDEADBEEF, rready=1.
  -> rready pulse at T, rvalid and rlast at T+3 with rdata=0xDEADBEEF, FSM back in IDLE at T+4.
- Burst read: rlen=4 at araddr 0x100, rready low for 2 cycles on beat 2.
  -> sram_addr steps 0x40..0x43, rdata/rlast held stable while stalled, rlast only on beat 4.
- Burst write: wlen=2 at 0x200, wstrb=4'b0011, data 0x11223344 / 0x55667788.
  -> two we_n low pulses at addresses 0x80 and 0x81, be_n=4'b1100, bvalid held until bready.
- Simultaneous awvalid and arvalid in IDLE.
  -> awready first, read not acknowledged until the write's bvalid/bready completes.
- Address wrap: read of rlen=2 starting at word 0xFFFFF -> second access at sram_addr 0x00000.
- Reset asserted during a WR_PULSE beat.
  -> we_n=1, dq_oe=0, resp=0 immediately, and a fresh read afterwards completes normally.
- With BUS_WLAST_CHECK_EN: wlen=3 with wlast on beat 2 -> protocol_err=1, remaining beat still written.
